sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl_if.sv | 22 ++
 rtl/sram_ctrl.sv | 134 +++++++++++++
 tb/tb_sram_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Request bus between the cache-line burst wrapper and sram_ctrl.
// One 48-bit word moves per accepted strobe. wb_nak high means the controller is busy.
interface sram_ctrl_if;
  logic        wb_stb;
  logic [31:0] wb_addr;
  logic [5:0]  wb_we;
  logic [47:0] wb_din;
  logic [47:0] wb_dout;
  logic        wb_nak;

  // Requester side (burst wrapper or testbench)
  modport master (
    output wb_stb, wb_addr, wb_we, wb_din,
    input  wb_dout, wb_nak
  );

  // Controller side
  modport slave (
    input  wb_stb, wb_addr, wb_we, wb_din,
    output wb_dout, wb_nak
  );
endinterface

// File: rtl/sram_ctrl.sv
// Single-access controller for three asynchronous 16-bit SRAMs that form one 48-bit word.
// Each accepted strobe does exactly one read (mask == 0) or one masked write.
// All pin outputs come from flops, so the pins are glitch-free.
// Define SRAM_WAIT_STATE_EN to add one WAIT cycle after ACCESS for slower parts.
// In that build, read data is sampled at the end of WAIT.
module sram_ctrl (
  input  logic              clk,
  input  logic              rst,
  output logic [2:0]        sram_ce_n,
  output logic [2:0]        sram_oe_n,
  output logic [2:0]        sram_we_n,
  output logic [2:0]        sram_ub_n,
  output logic [2:0]        sram_lb_n,
  output logic [19:0]       sram_addr,
  inout  wire  [47:0]       sram_data,
  sram_ctrl_if.slave        bus
);

`ifdef SRAM_WAIT_STATE_EN
  typedef enum logic [1:0] {StIdle, StAccess, StWait} state_t;
`else
  typedef enum logic [1:0] {StIdle, StAccess} state_t;
`endif

  state_t      state_q;
  logic        rd_q;        // captured mask was all zero
  logic        drive_q;     // registered bus enable, set only for writes
  logic [47:0] wdata_q;
  logic [47:0] dout_q;

  logic [2:0]  acc_ce_n;
  logic [2:0]  acc_oe_n;
  logic [2:0]  acc_we_n;
  logic [2:0]  acc_ub_n;
  logic [2:0]  acc_lb_n;

  // Only bits [21:2] form the word address; the rest of the byte address is don't-care.
  logic unused_addr;
  assign unused_addr = ^{bus.wb_addr[31:22], bus.wb_addr[1:0]};

  assign bus.wb_nak  = (state_q != StIdle);
  assign bus.wb_dout = dout_q;
  assign sram_data   = drive_q ? wdata_q : 'z;

  // Decode the incoming byte mask into the per-chip pin levels for the access cycles
  always_comb begin
    acc_ce_n = '1;
    acc_oe_n = '1;
    acc_we_n = '1;
    acc_ub_n = '1;
    acc_lb_n = '1;
    if (bus.wb_we == '0) begin
      acc_ce_n = '0;
      acc_oe_n = '0;
      acc_ub_n = '0;
      acc_lb_n = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        // A chip with no byte selected keeps every control high
        acc_ce_n[i] = ~|bus.wb_we[2*i +: 2];
        acc_we_n[i] = ~|bus.wb_we[2*i +: 2];
        acc_ub_n[i] = ~bus.wb_we[2*i+1];
        acc_lb_n[i] = ~bus.wb_we[2*i];
      end
    end
  end

  // Access sequencer: accept in IDLE, hold pins through ACCESS (and WAIT), then release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_q      <= 1'b0;
      drive_q   <= 1'b0;
      wdata_q   <= '0;
      dout_q    <= '0;
      sram_addr <= '0;
      sram_ce_n <= '1;
      sram_oe_n <= '1;
      sram_we_n <= '1;
      sram_ub_n <= '1;
      sram_lb_n <= '1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.wb_stb) begin
            sram_addr <= bus.wb_addr[21:2];
            wdata_q   <= bus.wb_din;
            rd_q      <= (bus.wb_we == '0);
            drive_q   <= (bus.wb_we != '0);
            sram_ce_n <= acc_ce_n;
            sram_oe_n <= acc_oe_n;
            sram_we_n <= acc_we_n;
            sram_ub_n <= acc_ub_n;
            sram_lb_n <= acc_lb_n;
            state_q   <= StAccess;
          end
        end
`ifdef SRAM_WAIT_STATE_EN
        StAccess: begin
          // Pins held unchanged for one extra cycle
          state_q <= StWait;
        end
        StWait: begin
          if (rd_q) begin
            dout_q <= sram_data;
          end
          drive_q   <= 1'b0;
          sram_ce_n <= '1;
          sram_oe_n <= '1;
          sram_we_n <= '1;
          sram_ub_n <= '1;
          sram_lb_n <= '1;
          state_q   <= StIdle;
        end
`else
        StAccess: begin
          if (rd_q) begin
            dout_q <= sram_data;
          end
          drive_q   <= 1'b0;
          sram_ce_n <= '1;
          sram_oe_n <= '1;
          sram_we_n <= '1;
          sram_ub_n <= '1;
          sram_lb_n <= '1;
          state_q   <= StIdle;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl in the default build, with a single ACCESS cycle.
// A behavioural SRAM drives the bus whenever all output enables are low.
// tri1 on the data bus makes a released bus read back as all ones.
module tb_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [19:0] sram_addr;
  tri1  [47:0] sram_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam logic [47:0] Released = {48{1'b1}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl_if bus ();

  sram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .bus       (bus)
  );

  // Read contents of the SRAM model
  function automatic logic [47:0] mdl_rd(input logic [19:0] a);
    if (a == 20'h4) return 48'h0000_1234_5678;
    return {28'hC0DE000, a};
  endfunction

  assign sram_data = (sram_oe_n == 3'b000) ? mdl_rd(sram_addr) : 'z;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pins_idle(input string tag);
    check({tag, "_ce"}, 48'(sram_ce_n), 48'h7);
    check({tag, "_oe"}, 48'(sram_oe_n), 48'h7);
    check({tag, "_we"}, 48'(sram_we_n), 48'h7);
    check({tag, "_ub"}, 48'(sram_ub_n), 48'h7);
    check({tag, "_lb"}, 48'(sram_lb_n), 48'h7);
    check({tag, "_bus"}, sram_data, Released);
  endtask

  initial begin
    logic        nak_s;
    int          waited;
    int          last_acc;
    logic [19:0] base_w;

    rst         = 1'b1;
    bus.wb_stb  = 1'b0;
    bus.wb_addr = '0;
    bus.wb_we   = '0;
    bus.wb_din  = '0;

    // Reset state
    #3;
    pins_idle("rst");
    check("rst_addr", 48'(sram_addr), 48'h0);
    check("rst_dout", bus.wb_dout, 48'h0);
    check("rst_nak", 48'(bus.wb_nak), 48'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Read of word 4
    bus.wb_stb  = 1'b1;
    bus.wb_addr = 32'h10;
    bus.wb_we   = 6'h00;
    @(posedge clk); #1;
    bus.wb_stb = 1'b0;
    check("rd_addr", 48'(sram_addr), 48'h4);
    check("rd_ce", 48'(sram_ce_n), 48'h0);
    check("rd_oe", 48'(sram_oe_n), 48'h0);
    check("rd_we", 48'(sram_we_n), 48'h7);
    check("rd_ub", 48'(sram_ub_n), 48'h0);
    check("rd_lb", 48'(sram_lb_n), 48'h0);
    check("rd_nak", 48'(bus.wb_nak), 48'h1);
    @(posedge clk); #1;
    check("rd_dout", bus.wb_dout, 48'h0000_1234_5678);
    check("rd_nak_done", 48'(bus.wb_nak), 48'h0);
    pins_idle("rd_end");

    // Full write of word 2
    bus.wb_stb  = 1'b1;
    bus.wb_addr = 32'h8;
    bus.wb_we   = 6'h3F;
    bus.wb_din  = 48'hAAAA_5555_1234;
    @(posedge clk); #1;
    bus.wb_stb = 1'b0;
    check("wr_addr", 48'(sram_addr), 48'h2);
    check("wr_ce", 48'(sram_ce_n), 48'h0);
    check("wr_we", 48'(sram_we_n), 48'h0);
    check("wr_oe", 48'(sram_oe_n), 48'h7);
    check("wr_data", sram_data, 48'hAAAA_5555_1234);
    check("wr_nak", 48'(bus.wb_nak), 48'h1);
    @(posedge clk); #1;
    pins_idle("wr_end");
    check("wr_dout_kept", bus.wb_dout, 48'h0000_1234_5678);

    // Partial write: chip 0 low byte only
    bus.wb_stb  = 1'b1;
    bus.wb_addr = 32'h20;
    bus.wb_we   = 6'b000001;
    bus.wb_din  = 48'h0000_0000_00BE;
    @(posedge clk); #1;
    bus.wb_stb = 1'b0;
    check("pw_ce", 48'(sram_ce_n), 48'h6);
    check("pw_we", 48'(sram_we_n), 48'h6);
    check("pw_lb", 48'(sram_lb_n), 48'h6);
    check("pw_ub", 48'(sram_ub_n), 48'h7);
    check("pw_oe", 48'(sram_oe_n), 48'h7);
    check("pw_data", 48'(sram_data[15:0]), 48'h00BE);
    @(posedge clk); #1;
    pins_idle("pw_end");

    // Burst of 16 reads, strobe held, wrapper-style handshake
    base_w   = 20'h40;
    last_acc = 0;
    bus.wb_stb = 1'b1;
    bus.wb_we  = 6'h00;
    for (int k = 0; k < 16; k++) begin
      bus.wb_addr = 32'h100 + 32'(4 * k);
      waited = 0;
      do begin
        @(negedge clk);
        nak_s = bus.wb_nak;
        @(posedge clk);
        waited++;
      end while (nak_s && waited < 8);
      #1;
      check("burst_accept", 48'(nak_s), 48'h0);
      check("burst_addr", 48'(sram_addr), 48'(base_w + 20'(k)));
      if (k > 0) begin
        check("burst_gap", 48'(cyc - last_acc), 48'd2);
        check("burst_data", bus.wb_dout, {28'hC0DE000, base_w + 20'(k - 1)});
      end
      last_acc = cyc;
    end
    bus.wb_stb = 1'b0;
    @(posedge clk); #1;
    check("burst_last", bus.wb_dout, {28'hC0DE000, base_w + 20'd15});
    check("burst_nak_end", 48'(bus.wb_nak), 48'h0);

    // Abort: reset asserted in the middle of a write access
    bus.wb_stb  = 1'b1;
    bus.wb_addr = 32'h30;
    bus.wb_we   = 6'h3F;
    bus.wb_din  = 48'h1234_5678_9ABC;
    @(posedge clk); #1;
    bus.wb_stb = 1'b0;
    check("ab_we_active", 48'(sram_we_n), 48'h0);
    check("ab_data", sram_data, 48'h1234_5678_9ABC);
    #2 rst = 1'b1;
    #1;
    pins_idle("ab");
    check("ab_nak", 48'(bus.wb_nak), 48'h0);
    check("ab_dout", bus.wb_dout, 48'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    pins_idle("ab_after");
    check("ab_nak_after", 48'(bus.wb_nak), 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
